// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbitration bundle: requester side, back-pressure/flush, and the registered broadcast.
// master = requesters and tag-FIFO side; slave = the arbiter.
interface cdb_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int W_TAG  = 6,
    parameter int W_DATA = 32,
    parameter int W_SRC  = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*W_TAG-1:0]  req_tag;
    logic [N_REQ*W_DATA-1:0] req_data;
    logic [N_REQ-1:0]        req_grant;
    logic                    tagfifo_full;
    logic                    flush;
    logic                    cdb_valid;
    logic [W_TAG-1:0]        cdb_tag;
    logic [W_DATA-1:0]       cdb_data;
    logic [W_SRC-1:0]        cdb_src;

    modport master (
        output req_valid, req_tag, req_data, tagfifo_full, flush,
        input  req_grant, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  req_valid, req_tag, req_data, tagfifo_full, flush,
        output req_grant, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: combinational one-hot grant, winner registered onto the CDB 1 cycle later; flush/tagfifo_full block grants.
// CDB_ARB_RR_EN selects round-robin from a rotating pointer; undefined gives fixed priority (lowest index wins).
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int W_TAG  = 6,
    parameter int W_DATA = 32,
    parameter int W_SRC  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    cdb_arbiter_if.slave bus
);
    logic [N_REQ-1:0] grant;
    logic [W_SRC-1:0] win;
    logic             found;
    logic             grant_en;
    logic [W_SRC-1:0] win_lo;
    logic             any_lo;
`ifdef CDB_ARB_RR_EN
    logic [W_SRC-1:0] ptr;
    logic [W_SRC-1:0] win_hi;
    logic             any_hi;
`endif

    // Descending scan leaves the lowest matching index; the "hi" pass only
    // considers indices at or above ptr, so it wins over the wrapped pass.
    always_comb begin
        win_lo = '0;
        any_lo = 1'b0;
`ifdef CDB_ARB_RR_EN
        win_hi = '0;
        any_hi = 1'b0;
`endif
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                any_lo = 1'b1;
                win_lo = W_SRC'(i);
            end
`ifdef CDB_ARB_RR_EN
            if (bus.req_valid[i] && (W_SRC'(i) >= ptr)) begin
                any_hi = 1'b1;
                win_hi = W_SRC'(i);
            end
`endif
        end
    end

`ifdef CDB_ARB_RR_EN
    assign found = any_hi | any_lo;
    assign win   = any_hi ? win_hi : win_lo;
`else
    assign found = any_lo;
    assign win   = win_lo;
`endif

    assign grant_en      = reset_n & ~bus.flush & ~bus.tagfifo_full;
    assign grant         = (found && grant_en) ? (N_REQ'(1) << win) : '0;
    assign bus.req_grant = grant;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_data  <= '0;
            bus.cdb_src   <= '0;
        end else begin
            bus.cdb_valid <= |grant;
            if (|grant) begin
                bus.cdb_tag  <= bus.req_tag[win*W_TAG +: W_TAG];
                bus.cdb_data <= bus.req_data[win*W_DATA +: W_DATA];
                bus.cdb_src  <= win;
            end
        end
    end

`ifdef CDB_ARB_RR_EN
    // Pointer only advances on an actual grant, so flush/full/idle leave it alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (win == W_SRC'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end
`endif
endmodule
